// File: rtl/mem_access_arbiter_if.sv
// Request, grant, read-return and memory-side signals of the memory access arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic              IGrant;
    logic [DATA_W-1:0] IRdData;
    logic              IRdValid;

    logic              DReq;
    logic              DWe;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWrData;
    logic              DGrant;
    logic [DATA_W-1:0] DRdData;
    logic              DRdValid;

    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemData;
    logic [DATA_W-1:0] MemOutData;

    logic [15:0]       StallCount;

    modport slave (
        input  IReq, IAddr, DReq, DWe, DAddr, DWrData, MemOutData,
        output IGrant, IRdData, IRdValid, DGrant, DRdData, DRdValid,
        output MemWe, MemAddr, MemData, StallCount
    );

    modport master (
        output IReq, IAddr, DReq, DWe, DAddr, DWrData, MemOutData,
        input  IGrant, IRdData, IRdValid, DGrant, DRdData, DRdValid,
        input  MemWe, MemAddr, MemData, StallCount
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Arbitrates instruction-fetch and data ports onto a single-port 1-cycle-latency RAM.
// Define ARB_ROUND_ROBIN_EN for alternating grants instead of fixed priority + starvation guard.
module mem_access_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic                 clk,
    input logic                 Reset_n,
    mem_access_arbiter_if.slave bus
);
    typedef struct packed {
        logic valid;
        logic port_d;
        logic we;
    } tag_t;

    logic i_grant;
    logic d_grant;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d_q=1 means the data port won the latest grant; reset leaves data preferred.
    logic last_d_q, last_d_d;

    always_comb begin
        i_grant  = 1'b0;
        if (Reset_n && bus.IReq) begin
            i_grant = !bus.DReq || last_d_q;
        end
        d_grant  = Reset_n && bus.DReq && !i_grant;
        last_d_d = last_d_q;
        if (d_grant) begin
            last_d_d = 1'b1;
        end else if (i_grant) begin
            last_d_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    logic          starved;

    always_comb begin
        starved  = (starve_q == SW'(STARVE_LIMIT));
        i_grant  = Reset_n && bus.IReq && (!bus.DReq || starved);
        d_grant  = Reset_n && bus.DReq && !i_grant;
        starve_d = '0;
        if (bus.IReq && !i_grant) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    tag_t              tag1_q, tag1_d;
    tag_t              tag2_q;
    logic [15:0]       stall_q, stall_d;

    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        tag1_d     = '0;
        if (d_grant) begin
            mem_we_d   = bus.DWe;
            mem_addr_d = bus.DAddr;
            mem_data_d = bus.DWrData;
            tag1_d     = '{valid: 1'b1, port_d: 1'b1, we: bus.DWe};
        end else if (i_grant) begin
            mem_addr_d = bus.IAddr;
            tag1_d     = '{valid: 1'b1, port_d: 1'b0, we: 1'b0};
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (((bus.IReq && !i_grant) || (bus.DReq && !d_grant)) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            stall_q    <= '0;
        end else begin
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            stall_q    <= stall_d;
        end
    end

    // Return stage per port: gi=0 instruction, gi=1 data. Data holds until that port's next read.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            logic              rd_valid_q, rd_valid_d;
            logic [DATA_W-1:0] rd_data_q, rd_data_d;

            always_comb begin
                rd_valid_d = tag2_q.valid && !tag2_q.we && (tag2_q.port_d == 1'(gi));
                rd_data_d  = rd_data_q;
                if (rd_valid_d) begin
                    rd_data_d = bus.MemOutData;
                end
            end

            always_ff @(posedge clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else begin
                    rd_valid_q <= rd_valid_d;
                    rd_data_q  <= rd_data_d;
                end
            end
        end
    endgenerate

    assign bus.IGrant     = i_grant;
    assign bus.DGrant     = d_grant;
    assign bus.MemWe      = mem_we_q;
    assign bus.MemAddr    = mem_addr_q;
    assign bus.MemData    = mem_data_q;
    assign bus.IRdValid   = g_ret[0].rd_valid_q;
    assign bus.IRdData    = g_ret[0].rd_data_q;
    assign bus.DRdValid   = g_ret[1].rd_valid_q;
    assign bus.DRdData    = g_ret[1].rd_data_q;
    assign bus.StallCount = stall_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: RAM model, reference model of grants and
// read returns, per-cycle comparison, plus literal expectations per test step.
module tb_mem_access_arbiter;
    localparam int ADDR_W       = 13;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 4;

    logic clk     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_access_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk    (clk),
        .Reset_n(Reset_n),
        .bus    (bus.slave)
    );

    // Single-port synchronous RAM, one cycle read latency
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.MemWe) ram[bus.MemAddr] <= bus.MemData;
        bus.MemOutData <= ram[bus.MemAddr];
    end

    // Reference model: reads return shadow contents 2 edges after their grant
    typedef struct {
        int               due;
        bit               is_d;
        logic [DATA_W-1:0] data;
    } rd_t;
    rd_t               rq[$];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    int                m_edge = 0;
    int                m_starve = 0;
    bit                m_last_d = 1'b0;
    int                m_stall = 0;
    bit                m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    bit                m_iv = 1'b0, m_dv = 1'b0;
    logic [DATA_W-1:0] m_id = '0, m_dd = '0;
    bit                quiet = 1'b0;
    int                checks = 0;
    int                failures = 0;

    function automatic void exp_grant(output bit gi, output bit gd);
        gi = 1'b0;
        gd = 1'b0;
        if (Reset_n) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.IReq && bus.DReq) begin
                gi = m_last_d;
                gd = !m_last_d;
            end else begin
                gi = bus.IReq;
                gd = bus.DReq;
            end
`else
            if (bus.DReq && !(bus.IReq && m_starve >= STARVE_LIMIT)) gd = 1'b1;
            else gi = bus.IReq;
`endif
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge Reset_n) begin
        bit gi, gd;
        if (!Reset_n) begin
            rq.delete();
            m_starve = 0; m_last_d = 1'b0; m_stall = 0;
            m_we = 1'b0; m_addr = '0; m_data = '0;
            m_iv = 1'b0; m_dv = 1'b0; m_id = '0; m_dd = '0;
        end else begin
            exp_grant(gi, gd);
            m_edge++;
            m_iv = 1'b0;
            m_dv = 1'b0;
            if (rq.size() > 0 && rq[0].due == m_edge) begin
                if (rq[0].is_d) begin m_dv = 1'b1; m_dd = rq[0].data; end
                else begin m_iv = 1'b1; m_id = rq[0].data; end
                void'(rq.pop_front());
            end
            if (((bus.IReq && !gi) || (bus.DReq && !gd)) && m_stall < 65535) m_stall++;
            if (bus.IReq && !gi) m_starve++;
            else m_starve = 0;
            if (gi || gd) m_last_d = gd;
            m_we = gd && bus.DWe;
            if (gd) begin
                m_addr = bus.DAddr;
                if (bus.DWe) begin
                    m_data = bus.DWrData;
                    shadow[bus.DAddr] = bus.DWrData;
                end else begin
                    rq.push_back('{m_edge + 2, 1'b1, shadow[bus.DAddr]});
                end
            end else if (gi) begin
                m_addr = bus.IAddr;
                rq.push_back('{m_edge + 2, 1'b0, shadow[bus.IAddr]});
            end
            if (!quiet && (gi || gd))
                $display("txn t=%0t port=%s we=%0d addr=%h wdata=%h", $time,
                         gd ? "D" : "I", gd && bus.DWe, gd ? bus.DAddr : bus.IAddr, bus.DWrData);
        end
    end

    always @(negedge clk) begin
        bit gi, gd;
        exp_grant(gi, gd);
        check("IGrant", bus.IGrant, gi);
        check("DGrant", bus.DGrant, gd);
        check("MemWe", bus.MemWe, m_we);
        check("MemAddr", bus.MemAddr, m_addr);
        if (m_we) check("MemData", bus.MemData, m_data);
        check("IRdValid", bus.IRdValid, m_iv);
        check("DRdValid", bus.DRdValid, m_dv);
        check("IRdData", bus.IRdData, m_id);
        check("DRdData", bus.DRdData, m_dd);
        check("StallCount", bus.StallCount, m_stall);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.IReq = 1'b0;
        bus.DReq = 1'b0;
        bus.DWe  = 1'b0;
    endtask

    initial begin
        bus.IReq = 1'b0; bus.IAddr = '0;
        bus.DReq = 1'b0; bus.DWe = 1'b0; bus.DAddr = '0; bus.DWrData = '0;
        Reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_MemWe", bus.MemWe, 0);
        check("rst_StallCount", bus.StallCount, 0);
        check("rst_IRdValid", bus.IRdValid, 0);
        Reset_n = 1'b1;
        tick();

        // Write BEEF to 0x0010, then read it back on the next cycle
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 13'h0010; bus.DWrData = 16'hBEEF;
        #1;
        check("t1_DGrant", bus.DGrant, 1);
        check("t1_IGrant", bus.IGrant, 0);
        tick();
        check("t1_MemWe", bus.MemWe, 1);
        check("t1_MemAddr", bus.MemAddr, 32'h0010);
        check("t1_MemData", bus.MemData, 32'hBEEF);
        bus.DWe = 1'b0;
        #1;
        check("t2_DGrant", bus.DGrant, 1);
        tick();
        check("t1_MemWe_low", bus.MemWe, 0);
        bus.DReq = 1'b0;
        tick();
        check("t1_no_wr_valid", bus.DRdValid, 0);
        tick();
        check("t2_DRdValid", bus.DRdValid, 1);
        check("t2_DRdData", bus.DRdData, 32'hBEEF);
        tick();
        check("t2_DRdValid_pulse", bus.DRdValid, 0);

        // Preload 0..3 with 0x1000+addr through the data port
        for (int k = 0; k < 4; k++) begin
            bus.DReq = 1'b1; bus.DWe = 1'b1;
            bus.DAddr = 13'(k); bus.DWrData = 16'h1000 + 16'(k);
            tick();
        end
        idle();

        // Back-to-back instruction reads
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                bus.IReq = 1'b1;
                bus.IAddr = 13'(k);
            end else begin
                bus.IReq = 1'b0;
            end
            tick();
            if (k >= 2) begin
                check("t4_IRdValid", bus.IRdValid, 1);
                check("t4_IRdData", bus.IRdData, 32'h1000 + k - 2);
            end
        end
        tick();
        check("t4_IRdValid_end", bus.IRdValid, 0);
        check("t4_IRdData_hold", bus.IRdData, 32'h1003);

        // Both ports request continuously
        bus.IReq = 1'b1; bus.IAddr = 13'h0000;
        bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 13'h0001;
        for (int i = 0; i < 10; i++) begin
            bit exp_i;
`ifdef ARB_ROUND_ROBIN_EN
            exp_i = (i % 2 == 1);
`else
            exp_i = (i % 5 == 4);
`endif
            #1;
            check("t3_IGrant", bus.IGrant, exp_i);
            check("t3_DGrant", bus.DGrant, !exp_i);
            tick();
        end
        check("t3_StallCount", bus.StallCount, 10);

        // 65540 stalled cycles in total -> saturation
        quiet = 1'b1;
        repeat (65530) tick();
        check("t6_StallCount_sat", bus.StallCount, 32'hFFFF);
        tick();
        check("t6_StallCount_hold", bus.StallCount, 32'hFFFF);
        quiet = 1'b0;
        idle();
        repeat (4) tick();

        // Async reset while an instruction read and a write are in flight
        bus.IReq = 1'b1; bus.IAddr = 13'h0002;
        tick();
        bus.IReq = 1'b0;
        bus.DReq = 1'b1; bus.DWe = 1'b1; bus.DAddr = 13'h0020; bus.DWrData = 16'h5A5A;
        tick();
        idle();
        check("t5_MemWe_pre", bus.MemWe, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("t5_MemWe_async", bus.MemWe, 0);
        check("t5_MemAddr_async", bus.MemAddr, 0);
        check("t5_StallCount_async", bus.StallCount, 0);
        check("t5_IRdData_async", bus.IRdData, 0);
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_IRdValid", bus.IRdValid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
